// File: rtl/imem_fetch_responder.sv
// Instruction-memory fetch responder: fixed-latency read pipeline feeding an in-order
// first-word-fall-through response FIFO, with credit backpressure, flush and a load port.
module imem_fetch_responder #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned DEPTH_WORDS    = 1024,
    parameter int unsigned LATENCY        = 2,
    parameter int unsigned RSP_FIFO_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [ADDR_WIDTH-1:0]          req_addr,
    input  logic                           flush,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [DATA_WIDTH-1:0]          rsp_data,
    output logic [ADDR_WIDTH-1:0]          rsp_addr,
    output logic                           rsp_err,
    input  logic                           ld_en,
    input  logic [$clog2(DEPTH_WORDS)-1:0] ld_addr,
    input  logic [DATA_WIDTH-1:0]          ld_data
);

    localparam int unsigned IDX_W  = $clog2(DEPTH_WORDS);
    localparam int unsigned PTR_W  = (RSP_FIFO_DEPTH > 1) ? $clog2(RSP_FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W  = PTR_W + 1;
    // Stage 0 is the combinational read at the accepting edge, so only LATENCY-1 flop stages exist.
    localparam int unsigned PIPE_N = (LATENCY > 1) ? LATENCY - 1 : 1;

    typedef struct packed {
        logic                  err;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH_WORDS];

    logic              pipe_v_q [PIPE_N];
    logic              pipe_v_d [PIPE_N];
    entry_t            pipe_q   [PIPE_N];
    entry_t            pipe_d   [PIPE_N];
    entry_t            fifo_q   [RSP_FIFO_DEPTH];
    entry_t            fifo_d   [RSP_FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, out_q, out_d;
    logic              rsp_valid_q, rsp_valid_d;

    logic              accept, pop, push, req_err;
    logic              stg_v [LATENCY];
    entry_t            stg_e [LATENCY];
    entry_t            req_e;

    assign req_ready = (out_q < CNT_W'(RSP_FIFO_DEPTH)) && !flush;
    assign accept    = req_valid && req_ready;
    assign pop       = rsp_valid_q && rsp_ready;

    assign req_err   = (req_addr[1:0] != 2'b00) || (req_addr[ADDR_WIDTH-1:2+IDX_W] != '0);
    assign req_e     = '{err:  req_err,
                         addr: req_addr,
                         data: req_err ? '0 : mem_q[req_addr[2 +: IDX_W]]};

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RSP_FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        stg_v    = '{default: 1'b0};
        stg_e    = '{default: '0};
        pipe_v_d = '{default: 1'b0};
        pipe_d   = pipe_q;
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        out_d    = out_q;
        push     = 1'b0;

        stg_v[0] = accept;
        stg_e[0] = req_e;
        for (int unsigned k = 1; k < LATENCY; k++) begin
            stg_v[k] = pipe_v_q[k-1];
            stg_e[k] = pipe_q[k-1];
        end
        for (int unsigned k = 0; k + 1 < LATENCY; k++) begin
            pipe_v_d[k] = stg_v[k] && !flush;
            pipe_d[k]   = stg_e[k];
        end

        push = stg_v[LATENCY-1];
        if (push) begin
            fifo_d[wr_ptr_q] = stg_e[LATENCY-1];
            wr_ptr_d         = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
        out_d = out_q + CNT_W'(accept) - CNT_W'(pop);

        // Redirect wins over any concurrent accept, push or pop.
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
            out_d    = '0;
        end
        rsp_valid_d = (cnt_d != '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pipe_v_q    <= '{default: 1'b0};
            pipe_q      <= '{default: '0};
            fifo_q      <= '{default: '0};
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            out_q       <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            pipe_v_q    <= pipe_v_d;
            pipe_q      <= pipe_d;
            fifo_q      <= fifo_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            out_q       <= out_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    // Instruction storage: not reset, writable regardless of reset or flush.
    always_ff @(posedge clk) begin
        if (ld_en) begin
            mem_q[ld_addr] <= ld_data;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = fifo_q[rd_ptr_q].data;
    assign rsp_addr  = fifo_q[rd_ptr_q].addr;
    assign rsp_err   = fifo_q[rd_ptr_q].err;

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Directed self-checking bench for imem_fetch_responder at default parameters.
module tb_imem_fetch_responder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        flush;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [31:0] rsp_addr;
    logic        rsp_err;
    logic        ld_en;
    logic [9:0]  ld_addr;
    logic [31:0] ld_data;

    int n_checks = 0;
    int n_errors = 0;

    imem_fetch_responder dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .flush     (flush),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_addr  (rsp_addr),
        .rsp_err   (rsp_err),
        .ld_en     (ld_en),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] a);
        req_valid = v;
        req_addr  = a;
    endtask

    task automatic expect_rsp(input string tag, input logic [31:0] d, input logic [31:0] a, input logic e);
        check({tag, ".valid"}, 64'(rsp_valid), 64'(1));
        check({tag, ".data"},  64'(rsp_data),  64'(d));
        check({tag, ".addr"},  64'(rsp_addr),  64'(a));
        check({tag, ".err"},   64'(rsp_err),   64'(e));
    endtask

    initial begin
        reset_n = 1'b0; req_valid = 1'b0; req_addr = '0; flush = 1'b0;
        rsp_ready = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        #2;
        check("rst.rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst.rsp_data",  64'(rsp_data),  64'(0));
        check("rst.rsp_addr",  64'(rsp_addr),  64'(0));
        check("rst.rsp_err",   64'(rsp_err),   64'(0));
        check("rst.req_ready", 64'(req_ready), 64'(1));
        repeat (2) tick();
        reset_n = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            ld_en = 1'b1; ld_addr = 10'(i); ld_data = 32'h1000_0000 + 32'(i);
            tick();
        end
        ld_en = 1'b0;

        // Back-to-back fetches with consumer always ready.
        rsp_ready = 1'b1;
        drive(1'b1, 32'h0); tick();
        check("b2b.lat0", 64'(rsp_valid), 64'(0));
        drive(1'b1, 32'h4); tick();
        expect_rsp("b2b.r0", 32'h1000_0000, 32'h0, 1'b0);
        drive(1'b1, 32'h8); tick();
        expect_rsp("b2b.r1", 32'h1000_0001, 32'h4, 1'b0);
        drive(1'b0, 32'h0); tick();
        expect_rsp("b2b.r2", 32'h1000_0002, 32'h8, 1'b0);
        tick();
        check("b2b.drain", 64'(rsp_valid), 64'(0));

        // Backpressure: only four credits.
        rsp_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, (i < 4) ? 32'(i * 4) : 32'h20);
            #1;
            check($sformatf("bp.ready%0d", i), 64'(req_ready), 64'((i < 4) ? 1 : 0));
            tick();
        end
        drive(1'b0, 32'h0);
        tick();
        expect_rsp("bp.head", 32'h1000_0000, 32'h0, 1'b0);
        check("bp.ready_full", 64'(req_ready), 64'(0));
        rsp_ready = 1'b1;
        tick();
        check("bp.ready_after_pop", 64'(req_ready), 64'(1));
        expect_rsp("bp.r1", 32'h1000_0001, 32'h4, 1'b0);
        tick();
        expect_rsp("bp.r2", 32'h1000_0002, 32'h8, 1'b0);
        tick();
        expect_rsp("bp.r3", 32'h1000_0003, 32'hC, 1'b0);
        tick();
        check("bp.drain", 64'(rsp_valid), 64'(0));

        // Misaligned and out-of-range fetches around a good one.
        drive(1'b1, 32'h6); tick();
        drive(1'b1, 32'h8); tick();
        expect_rsp("err.mis", 32'h0, 32'h6, 1'b1);
        drive(1'b1, 32'h1000); tick();
        expect_rsp("err.good", 32'h1000_0002, 32'h8, 1'b0);
        drive(1'b0, 32'h0); tick();
        expect_rsp("err.oor", 32'h0, 32'h1000, 1'b1);
        tick();
        check("err.drain", 64'(rsp_valid), 64'(0));

        // Flush discards buffered and in-flight fetches.
        rsp_ready = 1'b0;
        drive(1'b1, 32'h0); tick();
        drive(1'b1, 32'h4); tick();
        drive(1'b1, 32'h8); tick();
        drive(1'b1, 32'hC); flush = 1'b1;
        #1;
        check("fl.ready_during", 64'(req_ready), 64'(0));
        tick();
        flush = 1'b0; drive(1'b0, 32'h0);
        #1;
        check("fl.valid_after", 64'(rsp_valid), 64'(0));
        check("fl.ready_after", 64'(req_ready), 64'(1));
        rsp_ready = 1'b1;
        repeat (2) tick();
        check("fl.no_ghost", 64'(rsp_valid), 64'(0));
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h10 + 32'(i * 4));
            #1;
            check($sformatf("fl.credit%0d", i), 64'(req_ready), 64'(1));
            tick();
        end
        drive(1'b0, 32'h0);
        tick();
        expect_rsp("fl.next", 32'h1000_0004, 32'h10, 1'b0);
        rsp_ready = 1'b1;
        repeat (4) tick();
        check("fl.drain", 64'(rsp_valid), 64'(0));

        // Load and fetch of the same word on one edge return the old contents.
        ld_en = 1'b1; ld_addr = 10'd5; ld_data = 32'hDEAD_BEEF;
        drive(1'b1, 32'h14); tick();
        ld_en = 1'b0;
        drive(1'b1, 32'h14); tick();
        expect_rsp("ld.old", 32'h1000_0005, 32'h14, 1'b0);
        drive(1'b0, 32'h0); tick();
        expect_rsp("ld.new", 32'hDEAD_BEEF, 32'h14, 1'b0);
        tick();

        // Asynchronous reset with responses pending.
        rsp_ready = 1'b0;
        drive(1'b1, 32'h0); tick();
        drive(1'b1, 32'h4); tick();
        drive(1'b0, 32'h0); tick();
        expect_rsp("ar.pending", 32'h1000_0000, 32'h0, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        check("ar.rsp_valid", 64'(rsp_valid), 64'(0));
        check("ar.rsp_data",  64'(rsp_data),  64'(0));
        check("ar.rsp_addr",  64'(rsp_addr),  64'(0));
        tick();
        #2 reset_n = 1'b1;
        tick();
        check("ar.ready", 64'(req_ready), 64'(1));
        check("ar.valid", 64'(rsp_valid), 64'(0));
        rsp_ready = 1'b1;
        drive(1'b1, 32'h1C); tick();
        drive(1'b1, 32'h14); tick();
        expect_rsp("ar.mem7", 32'h1000_0007, 32'h1C, 1'b0);
        drive(1'b0, 32'h0); tick();
        expect_rsp("ar.mem5", 32'hDEAD_BEEF, 32'h14, 1'b0);
        tick();
        check("ar.drain", 64'(rsp_valid), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
